// File: rtl/l2_flush_sequencer.sv
// -----------------------------------------------------------------------------
// l2_flush_pkg / l2_flush_sequencer
//
// Purpose:
//   Flushes a contiguous range of L2 cache lines. After a start strobe it
//   issues one flush request per line into an L2 arbiter port, keeping at most
//   MAX_OUTSTANDING requests in flight, counts the matching flush acks on the
//   L2 response bus and pulses done once every line has been acknowledged.
//
// Handshake:
//   req_valid/req_line/req_id are registered. A request transfers on a cycle
//   where req_valid && req_ready; once raised, req_valid stays high and
//   req_line/req_id stay stable until that transfer happens.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-low reset
//   start_en         one-cycle start strobe, honoured only when idle
//   start_line       first cache-line address (byte address bits [31:6])
//   line_count       number of lines to flush (0 is legal)
//   busy             high while a flush range is in progress
//   done             one-cycle completion pulse
//   req_valid        flush request valid
//   req_ready        arbiter accepts the request this cycle
//   req_line         cache-line address of the request
//   req_core         requester core id (constant REQUESTER_CORE)
//   req_id           issue counter modulo MAX_OUTSTANDING
//   rsp_valid        L2 response bus valid
//   rsp_packet_type  L2 response type
//   rsp_core         L2 response destination core
//   state_dbg        current FSM state (debug visibility)
// -----------------------------------------------------------------------------
package l2_flush_pkg;
   typedef logic [1:0] core_id_t;

   typedef enum logic [2:0] {
      L2RSP_LOAD_ACK  = 3'd0,
      L2RSP_STORE_ACK = 3'd1,
      L2RSP_FLUSH_ACK = 3'd2,
      L2RSP_INVAL     = 3'd3
   } l2rsp_packet_type_t;
endpackage

module l2_flush_sequencer
   import l2_flush_pkg::*;
#(
   parameter int       MAX_OUTSTANDING = 4,
   parameter int       COUNT_WIDTH     = 16,
   parameter core_id_t REQUESTER_CORE  = 2'd0,
   localparam int      ID_WIDTH        = $clog2(MAX_OUTSTANDING)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_en,
   input  logic [25:0]              start_line,
   input  logic [COUNT_WIDTH-1:0]   line_count,
   output logic                     busy,
   output logic                     done,
   output logic                     req_valid,
   input  logic                     req_ready,
   output logic [25:0]              req_line,
   output core_id_t                 req_core,
   output logic [ID_WIDTH-1:0]      req_id,
   input  logic                     rsp_valid,
   input  l2rsp_packet_type_t       rsp_packet_type,
   input  core_id_t                 rsp_core,
   output logic [1:0]               state_dbg
);

   // One extra bit so the in-flight counter can hold MAX_OUTSTANDING itself.
   localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                 state;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] issued;
   logic [COUNT_WIDTH-1:0] acked;
   logic [OUT_WIDTH-1:0]   outstanding;

   logic                   accept;
   logic                   ack_match;
   logic                   ack_take;
   logic [COUNT_WIDTH-1:0] issued_nxt;
   logic [COUNT_WIDTH-1:0] acked_nxt;
   logic [OUT_WIDTH-1:0]   outstanding_nxt;
   logic                   valid_nxt;

   assign req_core  = REQUESTER_CORE;
   assign state_dbg = state;

   // Counter updates for this cycle. An ack that finds nothing in flight can
   // not belong to the request being accepted in the same cycle, so it is
   // dropped rather than allowed to underflow the in-flight count.
   always_comb begin
      accept          = req_valid && req_ready;
      ack_match       = rsp_valid && (rsp_packet_type == L2RSP_FLUSH_ACK) &&
                        (rsp_core == REQUESTER_CORE);
      ack_take        = ack_match && (outstanding != '0) &&
                        ((state == S_ISSUE) || (state == S_DRAIN));
      issued_nxt      = issued + COUNT_WIDTH'(accept);
      acked_nxt       = acked + COUNT_WIDTH'(ack_take);
      outstanding_nxt = outstanding + OUT_WIDTH'(accept) - OUT_WIDTH'(ack_take);
      valid_nxt       = (issued_nxt < count_q) &&
                        (outstanding_nxt < OUT_WIDTH'(MAX_OUTSTANDING));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         req_valid   <= 1'b0;
         req_line    <= '0;
         req_id      <= '0;
         count_q     <= '0;
         issued      <= '0;
         acked       <= '0;
         outstanding <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_en) begin
                  count_q     <= line_count;
                  issued      <= '0;
                  acked       <= '0;
                  outstanding <= '0;
                  req_line    <= start_line;
                  req_id      <= '0;
                  busy        <= 1'b1;
                  // An empty range skips issuing; it spends one busy cycle in
                  // DRAIN, where acked==count holds at once and completes.
                  if (line_count == '0) begin
                     req_valid <= 1'b0;
                     state     <= S_DRAIN;
                  end else begin
                     req_valid <= 1'b1;
                     state     <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               issued      <= issued_nxt;
               acked       <= acked_nxt;
               outstanding <= outstanding_nxt;
               req_valid   <= valid_nxt;
               req_id      <= issued_nxt[ID_WIDTH-1:0];
               if (accept) begin
                  req_line <= req_line + 26'd1;
               end
               if (issued_nxt == count_q) begin
                  state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               acked       <= acked_nxt;
               outstanding <= outstanding_nxt;
               req_valid   <= 1'b0;
               // The completing ack is seen here, so done lands next cycle.
               if (acked_nxt == count_q) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_FINISH;
               end
            end

            S_FINISH: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // A flush ack with nothing in flight during an active range points at a
   // protocol error elsewhere in the L2.
   assert property (@(posedge clk) disable iff (!reset)
                    (busy && ack_match) |-> (outstanding != '0))
      else $error("l2_flush_sequencer: flush ack with no request outstanding");

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// -----------------------------------------------------------------------------
// tb_l2_flush_sequencer
//
// Purpose:
//   Self-checking bench for l2_flush_sequencer. A range-level model (lines
//   issued vs. acknowledged, as plain integers) predicts busy/done/req_valid/
//   req_line/req_id every cycle; directed scenarios add hand-computed literal
//   expectations (latencies, accept counts, line sequences).
//
// Timing: inputs are driven 1-2 time units after the rising edge, outputs are
// compared on the falling edge, the model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_l2_flush_sequencer;
   import l2_flush_pkg::*;

   localparam int       MAX_OUT  = 4;
   localparam int       CW       = 16;
   localparam int       IDW      = 2;
   localparam core_id_t REQ_CORE = 2'd0;

   typedef struct packed {
      l2rsp_packet_type_t kind;
      core_id_t           core;
   } rsp_t;

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic               start_en   = 1'b0;
   logic [25:0]        start_line = '0;
   logic [CW-1:0]      line_count = '0;
   logic               busy;
   logic               done;
   logic               req_valid;
   logic               req_ready  = 1'b0;
   logic [25:0]        req_line;
   core_id_t           req_core;
   logic [IDW-1:0]     req_id;
   logic               rsp_valid  = 1'b0;
   l2rsp_packet_type_t rsp_packet_type = L2RSP_LOAD_ACK;
   core_id_t           rsp_core   = 2'd0;
   logic [1:0]         state_dbg;

   l2_flush_sequencer #(
      .MAX_OUTSTANDING (MAX_OUT),
      .COUNT_WIDTH     (CW),
      .REQUESTER_CORE  (REQ_CORE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start_en        (start_en),
      .start_line      (start_line),
      .line_count      (line_count),
      .busy            (busy),
      .done            (done),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_line        (req_line),
      .req_core        (req_core),
      .req_id          (req_id),
      .rsp_valid       (rsp_valid),
      .rsp_packet_type (rsp_packet_type),
      .rsp_core        (rsp_core),
      .state_dbg       (state_dbg)
   );

   // ---------------------------------------------------------------- bookkeeping
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // A range is described by how many lines were handed out and how many came
   // back; everything visible follows from those two numbers.
   int          cyc       = 0;
   bit          m_busy    = 1'b0;
   bit          m_done    = 1'b0;
   int          m_count   = 0;
   int          m_issued  = 0;
   int          m_acked   = 0;
   logic [25:0] m_start   = '0;
   int          ack_delay = -1;
   int          acc_cnt   = 0;
   int          ack_due[$];
   rsp_t        noise_q[$];

   function automatic bit exp_valid();
      return m_busy && (m_issued < m_count) && ((m_issued - m_acked) < MAX_OUT);
   endfunction

   function automatic logic [25:0] exp_line();
      logic [25:0] off;
      off = m_issued[25:0];
      return m_start + off;
   endfunction

   function automatic logic [IDW-1:0] exp_id();
      int r;
      r = m_issued % MAX_OUT;
      return r[IDW-1:0];
   endfunction

   always @(posedge clk or negedge reset) begin
      bit acc;
      bit match;
      bit ack;
      if (!reset) begin
         m_busy   = 1'b0;
         m_done   = 1'b0;
         m_count  = 0;
         m_issued = 0;
         m_acked  = 0;
         ack_due.delete();
      end else begin
         match = rsp_valid && (rsp_packet_type == L2RSP_FLUSH_ACK) && (rsp_core == REQ_CORE);
         acc   = exp_valid() && req_ready;
         if (m_done) begin
            m_done = 1'b0;
         end else if (!m_busy) begin
            if (start_en) begin
               m_busy   = 1'b1;
               m_count  = int'(line_count);
               m_start  = start_line;
               m_issued = 0;
               m_acked  = 0;
            end
         end else begin
            ack = match && (m_issued > m_acked);
            if (acc) begin
               acc_cnt++;
               if (ack_delay >= 0) ack_due.push_back(cyc + ack_delay);
            end
            m_issued += int'(acc);
            m_acked  += int'(ack);
            if (m_issued == m_count && m_acked == m_count) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
         cyc++;
      end
   end

   // ---------------------------------------------------------------- responder
   always @(posedge clk) begin
      rsp_t nz;
      #1;
      if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
         ack_due.delete(0);
         rsp_valid       = 1'b1;
         rsp_packet_type = L2RSP_FLUSH_ACK;
         rsp_core        = REQ_CORE;
      end else if (noise_q.size() > 0) begin
         nz              = noise_q.pop_front();
         rsp_valid       = 1'b1;
         rsp_packet_type = nz.kind;
         rsp_core        = nz.core;
      end else begin
         rsp_valid       = 1'b0;
         rsp_packet_type = L2RSP_LOAD_ACK;
         rsp_core        = 2'd0;
      end
   end

   task automatic push_noise(input l2rsp_packet_type_t kind, input core_id_t core);
      rsp_t nz;
      nz.kind = kind;
      nz.core = core;
      noise_q.push_back(nz);
   endtask

   // ---------------------------------------------------------------- scoreboard
   logic [25:0]    exp_q[$];
   logic [IDW-1:0] exp_id_q[$];
   int busy_seen  = 0;
   int done_seen  = 0;
   int valid_seen = 0;
   int first_acc  = -1;
   int last_acc   = -1;

   always @(negedge clk) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("req_valid", {31'd0, req_valid}, {31'd0, exp_valid()});
      check("req_core", {30'd0, req_core}, {30'd0, REQ_CORE});
      if (exp_valid()) begin
         check("req_line", {6'd0, req_line}, {6'd0, exp_line()});
         check("req_id", {30'd0, req_id}, {30'd0, exp_id()});
         if (req_ready && exp_q.size() > 0) begin
            check("sb_line", {6'd0, req_line}, {6'd0, exp_q.pop_front()});
            check("sb_id", {30'd0, req_id}, {30'd0, exp_id_q.pop_front()});
         end
      end
      busy_seen  += int'(busy);
      done_seen  += int'(done);
      valid_seen += int'(req_valid);
      if (req_valid && req_ready) begin
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
   end

   // ---------------------------------------------------------------- drivers
   int start_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_stats();
      busy_seen  = 0;
      done_seen  = 0;
      valid_seen = 0;
      acc_cnt    = 0;
      first_acc  = -1;
      last_acc   = -1;
   endtask

   task automatic do_start(input logic [25:0] line, input int cnt);
      start_line = line;
      line_count = cnt[CW-1:0];
      start_en   = 1'b1;
      start_cyc  = cyc;
      tick();
      start_en   = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles, output int lat);
      lat = -1;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - start_cyc;
            break;
         end
      end
      if (lat < 0) check({name, "_timeout"}, 32'd0, 32'd1);
      tick();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int lat;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, req_valid}, 32'd0);
      check("rst_line", {6'd0, req_line}, 32'd0);
      check("rst_id", {30'd0, req_id}, 32'd0);
      tick();
      reset = 1'b1;
      repeat (2) tick();

      // Basic range: 3 lines from 0x100, acks 4 cycles after acceptance
      clear_stats();
      req_ready = 1'b1;
      ack_delay = 4;
      exp_q     = '{26'h100, 26'h101, 26'h102};
      exp_id_q  = '{2'd0, 2'd1, 2'd2};
      do_start(26'h100, 3);
      wait_done("t_basic", 40, lat);
      check("t_basic_latency", lat, 32'd8);
      repeat (3) tick();
      check("t_basic_done_pulses", done_seen, 32'd1);
      check("t_basic_busy_cycles", busy_seen, 32'd7);
      check("t_basic_accepts", acc_cnt, 32'd3);

      // Reset mid-stream with 3 of 8 in flight, stray acks afterwards
      clear_stats();
      ack_delay = -1;
      do_start(26'h400, 8);
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("t_abort_accepts", acc_cnt, 32'd3);
      check("t_abort_busy", {31'd0, busy}, 32'd0);
      check("t_abort_valid", {31'd0, req_valid}, 32'd0);
      check("t_abort_done", {31'd0, done}, 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) push_noise(L2RSP_FLUSH_ACK, REQ_CORE);
      repeat (5) tick();
      @(negedge clk);
      check("t_abort_stray_busy", {31'd0, busy}, 32'd0);
      check("t_abort_stray_valid", {31'd0, req_valid}, 32'd0);
      tick();
      clear_stats();
      ack_delay = 2;
      exp_q     = '{26'h500, 26'h501};
      exp_id_q  = '{2'd0, 2'd1};
      do_start(26'h500, 2);
      wait_done("t_restart", 30, lat);
      check("t_restart_latency", lat, 32'd5);

      // Outstanding limit with acks withheld, plus non-matching responses
      clear_stats();
      ack_delay = -1;
      do_start(26'h2000, 10);
      repeat (8) tick();
      @(negedge clk);
      check("t_limit_accepts", acc_cnt, 32'd4);
      check("t_limit_valid_low", {31'd0, req_valid}, 32'd0);
      tick();
      push_noise(L2RSP_LOAD_ACK, REQ_CORE);
      push_noise(L2RSP_FLUSH_ACK, 2'd1);
      push_noise(L2RSP_STORE_ACK, REQ_CORE);
      push_noise(L2RSP_FLUSH_ACK, 2'd3);
      repeat (6) tick();
      check("t_limit_noise_accepts", acc_cnt, 32'd4);
      ack_due.push_back(cyc);
      repeat (6) tick();
      check("t_limit_release_one", acc_cnt, 32'd5);
      ack_delay = 2;
      for (int i = 0; i < 5; i++) ack_due.push_back(cyc + i);
      wait_done("t_limit", 100, lat);
      check("t_limit_total_accepts", acc_cnt, 32'd10);

      // Zero-length range
      clear_stats();
      do_start(26'h55, 0);
      wait_done("t_zero", 10, lat);
      check("t_zero_latency", lat, 32'd2);
      check("t_zero_busy_cycles", busy_seen, 32'd1);
      check("t_zero_valid_cycles", valid_seen, 32'd0);

      // Address wrap with the arbiter stalling for 5 cycles
      clear_stats();
      req_ready = 1'b0;
      ack_delay = 2;
      exp_q     = '{26'h3FFFFFF, 26'h0000000};
      exp_id_q  = '{2'd0, 2'd1};
      do_start(26'h3FFFFFF, 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t_wrap_hold_valid", {31'd0, req_valid}, 32'd1);
         check("t_wrap_hold_line", {6'd0, req_line}, 32'h3FFFFFF);
         check("t_wrap_hold_id", {30'd0, req_id}, 32'd0);
      end
      tick();
      req_ready = 1'b1;
      wait_done("t_wrap", 30, lat);
      check("t_wrap_latency", lat, 32'd10);

      // Full throughput at the limit, start while busy and while finishing
      clear_stats();
      ack_delay = 3;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(26'h300 + 26'(i));
         exp_id_q.push_back(2'(i));
      end
      do_start(26'h300, 8);
      tick();
      start_line = 26'h777;
      line_count = 16'd1;
      start_en   = 1'b1;
      tick();
      start_en   = 1'b0;
      for (int i = 0; i < 40 && cyc < start_cyc + 12; i++) tick();
      start_line = 26'h999;
      line_count = 16'd5;
      start_en   = 1'b1;
      @(negedge clk);
      check("t_tput_done_at_12", {31'd0, done}, 32'd1);
      tick();
      start_en = 1'b0;
      repeat (4) tick();
      check("t_tput_accept_span", last_acc - first_acc, 32'd7);
      check("t_tput_accepts", acc_cnt, 32'd8);
      check("t_tput_busy_cycles", busy_seen, 32'd11);
      check("t_tput_done_pulses", done_seen, 32'd1);

      check("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
